// File: rtl/hex_scan_display.sv
// hex_scan_display
// ----------------
// Time-multiplexed driver for a common-anode seven-segment display with
// NUM_DIGITS hex digits. A free-running prescaler of DIV_WIDTH bits sets the
// slot length (2^DIV_WIDTH clocks per digit). Incoming digits are captured
// into a shadow register on load and copied to the display register only at
// the frame wrap, so a frame never shows a mix of old and new digits.
//
// Optional build macro:
//   HEX_SCAN_LZB_EN - enables leading-zero blanking (digit 0 is never blanked;
//                     a lit decimal point keeps its digit and all lower digits
//                     visible).
//
// Ports:
//   clk        - sole clock, rising edge
//   rst        - synchronous active-high reset
//   value      - 4*NUM_DIGITS hex nibbles, nibble k drives digit k
//   dp         - per-digit decimal point request (1 = lit)
//   load       - captures {dp, value} into the shadow register
//   blank      - level, forces all digits dark
//   seg[7:1]   - active-low segments, seg[1] = a ... seg[7] = g
//   dp_n       - active-low decimal point of the selected digit
//   an         - active-low digit select, at most one bit low
//   frame_done - one-cycle pulse after the display register reloads

module hex_scan_display #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic                    blank,
    output logic [7:1]              seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    // NUM_DIGITS is at least 2, so the index is always at least one bit wide.
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int SH_W  = 5 * NUM_DIGITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [SH_W-1:0]       shadow_q, shadow_d;
    logic [SH_W-1:0]       disp_q, disp_d;
    logic                  frame_done_q, frame_done_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic       tick;
    logic       wrap;
    logic [3:0] cur_nibble;
    logic       cur_dp;
    logic       digit_dark;

    // Segment pattern as g..a, active low.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            4'h5:    return 7'b0010010;
            4'h6:    return 7'b0000010;
            4'h7:    return 7'b1111000;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0011000;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b0000011;
            4'hC:    return 7'b1000110;
            4'hD:    return 7'b0100001;
            4'hE:    return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    assign tick = &cnt_q;
    assign wrap = tick && (idx_q == LAST_IDX);

    // Pick the nibble and decimal point of the digit currently being scanned.
    always_comb begin
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nibble = disp_q[4*k +: 4];
                cur_dp     = disp_q[4*NUM_DIGITS + k];
            end
        end
    end

`ifdef HEX_SCAN_LZB_EN
    logic [NUM_DIGITS-1:0] lead_zero;

    // Walk from the most significant digit down: a digit is a leading zero
    // only while it and every higher digit have a zero nibble and no dp.
    always_comb begin
        logic run;
        run        = 1'b1;
        lead_zero  = '0;
        digit_dark = blank;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            run = run && (disp_q[4*k +: 4] == 4'h0) && !disp_q[4*NUM_DIGITS + k];
            lead_zero[k] = run;
        end
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k) && lead_zero[k]) begin
                digit_dark = 1'b1;
            end
        end
    end
`else
    assign digit_dark = blank;
`endif

    always_comb begin
        cnt_d        = cnt_q + DIV_WIDTH'(1);
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        disp_d       = disp_q;
        frame_done_d = wrap;
        an_d         = '1;
        seg_d        = '1;
        dp_n_d       = 1'b1;

        if (tick) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
        // disp reads shadow_q, so a load on the wrap edge waits a full frame.
        if (wrap) begin
            disp_d = shadow_q;
        end
        if (load) begin
            shadow_d = {dp, value};
        end

        if (!digit_dark) begin
            an_d   = ~(NUM_DIGITS'(1) << idx_q);
            seg_d  = hex_to_seg(cur_nibble);
            dp_n_d = ~cur_dp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            disp_q       <= '0;
            frame_done_q <= 1'b0;
            an_q         <= '1;
            seg_q        <= '1;
            dp_n_q       <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            disp_q       <= disp_d;
            frame_done_q <= frame_done_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_n_q       <= dp_n_d;
        end
    end

    assign seg        = seg_q;
    assign dp_n       = dp_n_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// tb_hex_scan_display
// -------------------
// Self-checking bench for hex_scan_display with NUM_DIGITS=4, DIV_WIDTH=2.
// A behavioural model running on the rising edge pushes the expected
// {an, seg, dp_n, frame_done} into a scoreboard queue; the scenario tasks pop
// on the falling edge and compare, alongside directed checks of specific
// digit patterns. Honours HEX_SCAN_LZB_EN when it is defined for the build.

module tb_hex_scan_display;

    localparam int ND = 4;
    localparam int DW = 2;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp    = 4'h0;
    logic        load  = 1'b0;
    logic        blank = 1'b0;
    logic [7:1]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dpn;
        logic       fd;
    } exp_t;

    exp_t sb[$];

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int          m_cnt    = 0;
    int          m_idx    = 0;
    logic [19:0] m_shadow = '0;
    logic [19:0] m_disp   = '0;

    hex_scan_display #(
        .NUM_DIGITS (ND),
        .DIV_WIDTH  (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp         (dp),
        .load       (load),
        .blank      (blank),
        .seg        (seg),
        .dp_n       (dp_n),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: predicts what the output registers hold after this edge.
    always @(posedge clk) begin
        exp_t       e;
        logic [3:0] nib;
        logic       lz;
        if (rst) begin
            e        = {4'hF, 7'h7F, 1'b1, 1'b0};
            m_cnt    = 0;
            m_idx    = 0;
            m_shadow = '0;
            m_disp   = '0;
        end else begin
            nib = m_disp[4*m_idx +: 4];
            lz  = 1'b0;
`ifdef HEX_SCAN_LZB_EN
            if (m_idx > 0) begin
                lz = 1'b1;
                for (int k = m_idx; k < ND; k++) begin
                    if (m_disp[4*k +: 4] != 4'h0 || m_disp[16+k]) lz = 1'b0;
                end
            end
`endif
            if (blank || lz) begin
                e = {4'hF, 7'h7F, 1'b1, 1'b0};
            end else begin
                e.an  = ~(4'b0001 << m_idx);
                e.seg = seg_tab[nib];
                e.dpn = ~m_disp[16+m_idx];
            end
            e.fd = (m_cnt == 3 && m_idx == 3);
            if (e.fd) m_disp = m_shadow;
            if (load) m_shadow = {dp, value};
            if (m_cnt == 3) m_idx = (m_idx + 1) % ND;
            m_cnt = (m_cnt + 1) % 4;
        end
        sb.push_back(e);
    end

    // Waits one falling edge and returns the prediction for the edge just past.
    task automatic pop_next(output exp_t e);
        @(negedge clk);
        if (sb.size() == 0) e = 'x;
        else e = sb.pop_front();
    endtask

    task automatic sync_sb();
        @(negedge clk);
        sb.delete();
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        sync_sb();
        total++;
        if (an !== 4'hF || seg !== 7'h7F || dp_n !== 1'b1 || frame_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got an=%b seg=%b dp_n=%b fd=%b want 1111 1111111 1 0",
                     an, seg, dp_n, frame_done);
        end
        rst = 1'b0;
        pop_next(e);
        total++;
        if ({an, seg, dp_n, frame_done} !== e) begin
            bad++;
            $display("[TB] FAIL reset_model got=%h want=%h", {an, seg, dp_n, frame_done}, e);
        end
        total++;
        if (an !== 4'b1110 || seg !== 7'b1000000) begin
            bad++;
            $display("[TB] FAIL first_digit got an=%b seg=%b want an=1110 seg=1000000", an, seg);
        end
    endtask

    task automatic test_scan();
        exp_t       e;
        logic [3:0] want_an;
        logic       want_fd;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        for (int i = 1; i <= 32; i++) begin
            pop_next(e);
            total++;
            if ({an, seg, dp_n, frame_done} !== e) begin
                bad++;
                $display("[TB] FAIL scan_model cycle=%0d got=%h want=%h", i, {an, seg, dp_n, frame_done}, e);
            end
            want_an = ~(4'b0001 << (((i - 1) / 4) % 4));
            want_fd = (i % 16 == 0);
            total++;
            if (an !== want_an || frame_done !== want_fd) begin
                bad++;
                $display("[TB] FAIL scan_order cycle=%0d got an=%b fd=%b want an=%b fd=%b",
                         i, an, frame_done, want_an, want_fd);
            end
        end
    endtask

    task automatic test_load_midframe();
        exp_t       e;
        logic [6:0] obs [4];
        sync_sb();
        for (int i = 0; i < 5; i++) begin
            pop_next(e);
            total++;
            if ({an, seg, dp_n, frame_done} !== e) begin
                bad++;
                $display("[TB] FAIL midload_pre got=%h want=%h", {an, seg, dp_n, frame_done}, e);
            end
        end
        value = 16'h12AF;
        dp    = 4'h0;
        load  = 1'b1;
        for (int i = 0; i < 48; i++) begin
            pop_next(e);
            load = 1'b0;
            total++;
            if ({an, seg, dp_n, frame_done} !== e) begin
                bad++;
                $display("[TB] FAIL midload_model cycle=%0d got=%h want=%h", i, {an, seg, dp_n, frame_done}, e);
            end
            if (i >= 32) begin
                case (an)
                    4'b1110: obs[0] = seg;
                    4'b1101: obs[1] = seg;
                    4'b1011: obs[2] = seg;
                    4'b0111: obs[3] = seg;
                    default: ;
                endcase
            end
        end
        total++;
        if (obs[0] !== 7'b0001110 || obs[1] !== 7'b0001000 || obs[2] !== 7'b0100100 || obs[3] !== 7'b1111001) begin
            bad++;
            $display("[TB] FAIL midload_digits got %b %b %b %b want 0001110 0001000 0100100 1111001",
                     obs[0], obs[1], obs[2], obs[3]);
        end
    endtask

    task automatic test_load_on_wrap();
        exp_t       e;
        bit         found;
        logic [6:0] f1_d0, f2_d0, f2_d1;
        sync_sb();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_cnt == 3 && m_idx == 3) found = 1'b1;
            else pop_next(e);
        end
        total++;
        if (!found) begin
            bad++;
            $display("[TB] FAIL wrap_wait got no wrap within 20 cycles want wrap");
        end else begin
            value = 16'h0005;
            load  = 1'b1;
            pop_next(e);
            load = 1'b0;
            for (int i = 1; i <= 32; i++) begin
                pop_next(e);
                total++;
                if ({an, seg, dp_n, frame_done} !== e) begin
                    bad++;
                    $display("[TB] FAIL wrapload_model cycle=%0d got=%h want=%h", i, {an, seg, dp_n, frame_done}, e);
                end
                if (an == 4'b1110 && i <= 16) f1_d0 = seg;
                if (an == 4'b1110 && i > 16)  f2_d0 = seg;
                if (an == 4'b1101 && i > 16)  f2_d1 = seg;
            end
            total++;
            if (f1_d0 !== 7'b0001110 || f2_d0 !== 7'b0010010 || f2_d1 !== 7'b1000000) begin
                bad++;
                $display("[TB] FAIL wrapload_frames got %b %b %b want 0001110 0010010 1000000",
                         f1_d0, f2_d0, f2_d1);
            end
        end
    endtask

    task automatic test_lzb();
        exp_t       e;
        logic [6:0] obs [4];
        int         dark;
        sync_sb();
        value = 16'h0050;
        dp    = 4'h0;
        load  = 1'b1;
        dark  = 0;
        for (int i = 0; i < 56; i++) begin
            pop_next(e);
            load = 1'b0;
            total++;
            if ({an, seg, dp_n, frame_done} !== e) begin
                bad++;
                $display("[TB] FAIL lzb_model cycle=%0d got=%h want=%h", i, {an, seg, dp_n, frame_done}, e);
            end
            if (i >= 40) begin
                case (an)
                    4'b1110: obs[0] = seg;
                    4'b1101: obs[1] = seg;
                    4'b1011: obs[2] = seg;
                    4'b0111: obs[3] = seg;
                    4'b1111: dark++;
                    default: ;
                endcase
            end
        end
        total++;
        if (obs[0] !== 7'b1000000 || obs[1] !== 7'b0010010) begin
            bad++;
            $display("[TB] FAIL lzb_low got %b %b want 1000000 0010010", obs[0], obs[1]);
        end
`ifdef HEX_SCAN_LZB_EN
        total++;
        if (dark != 8) begin
            bad++;
            $display("[TB] FAIL lzb_dark got %0d dark cycles want 8", dark);
        end
`else
        total++;
        if (dark != 0 || obs[2] !== 7'b1000000 || obs[3] !== 7'b1000000) begin
            bad++;
            $display("[TB] FAIL lzb_off got dark=%0d d2=%b d3=%b want 0 1000000 1000000", dark, obs[2], obs[3]);
        end
`endif
    endtask

    task automatic test_dp();
        exp_t e;
        int   dark;
        logic dpn3, dpn1;
        sync_sb();
        value = 16'h0000;
        dp    = 4'b1000;
        load  = 1'b1;
        dark  = 0;
        for (int i = 0; i < 56; i++) begin
            pop_next(e);
            load = 1'b0;
            total++;
            if ({an, seg, dp_n, frame_done} !== e) begin
                bad++;
                $display("[TB] FAIL dp_model cycle=%0d got=%h want=%h", i, {an, seg, dp_n, frame_done}, e);
            end
            if (i >= 40) begin
                if (an == 4'b0111) dpn3 = dp_n;
                if (an == 4'b1101) dpn1 = dp_n;
                if (an == 4'b1111) dark++;
            end
        end
        total++;
        if (dpn3 !== 1'b0 || dpn1 !== 1'b1 || dark != 0) begin
            bad++;
            $display("[TB] FAIL dp_digits got dpn3=%b dpn1=%b dark=%0d want 0 1 0", dpn3, dpn1, dark);
        end
    endtask

    task automatic test_blank();
        exp_t e;
        sync_sb();
        blank = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pop_next(e);
            total++;
            if (an !== 4'hF || seg !== 7'h7F || dp_n !== 1'b1) begin
                bad++;
                $display("[TB] FAIL blank_dark cycle=%0d got an=%b seg=%b dp_n=%b want 1111 1111111 1",
                         i, an, seg, dp_n);
            end
            total++;
            if ({an, seg, dp_n, frame_done} !== e) begin
                bad++;
                $display("[TB] FAIL blank_model cycle=%0d got=%h want=%h", i, {an, seg, dp_n, frame_done}, e);
            end
        end
        blank = 1'b0;
        for (int i = 0; i < 12; i++) begin
            pop_next(e);
            total++;
            if ({an, seg, dp_n, frame_done} !== e) begin
                bad++;
                $display("[TB] FAIL blank_resume cycle=%0d got=%h want=%h", i, {an, seg, dp_n, frame_done}, e);
            end
        end
    endtask

    task automatic test_reset_midframe();
        exp_t e;
        bit   found;
        sync_sb();
        value = 16'h12AF;
        load  = 1'b1;
        pop_next(e);
        load  = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_idx == 2 && m_cnt == 1) found = 1'b1;
            else pop_next(e);
        end
        total++;
        if (!found) begin
            bad++;
            $display("[TB] FAIL midreset_wait got idx never 2 want idx 2");
        end else begin
            rst = 1'b1;
            pop_next(e);
            total++;
            if (an !== 4'hF || seg !== 7'h7F || dp_n !== 1'b1 || frame_done !== 1'b0) begin
                bad++;
                $display("[TB] FAIL midreset_ones got an=%b seg=%b dp_n=%b fd=%b want 1111 1111111 1 0",
                         an, seg, dp_n, frame_done);
            end
            rst = 1'b0;
            pop_next(e);
            total++;
            if (an !== 4'b1110 || seg !== 7'b1000000) begin
                bad++;
                $display("[TB] FAIL midreset_restart got an=%b seg=%b want an=1110 seg=1000000", an, seg);
            end
            for (int i = 0; i < 20; i++) begin
                pop_next(e);
                total++;
                if ({an, seg, dp_n, frame_done} !== e) begin
                    bad++;
                    $display("[TB] FAIL midreset_model cycle=%0d got=%h want=%h", i, {an, seg, dp_n, frame_done}, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_midframe();
        test_load_on_wrap();
        test_lzb();
        test_dp();
        test_blank();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/hex_scan_display.md
HEX_SCAN_DISPLAY -- requirements
Module: hex_scan_display

Interface
REQ-001 SHALL provide parameter NUM_DIGITS, default 4, meaning number of multiplexed digits (legal 2..8).
REQ-002 SHALL provide parameter DIV_WIDTH, default 16, meaning refresh prescaler width; one digit slot lasts 2^DIV_WIDTH clocks.
REQ-003 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, reset; synchronous and active-high.
REQ-005 Port value, input, 4*NUM_DIGITS, hex nibbles; nibble k (bits 4k+3:4k) drives digit k, with digit 0 least significant.
REQ-006 Port dp, input, NUM_DIGITS, decimal-point request per digit (1 = lit).
REQ-007 Port load, input, 1, strobe that captures value and dp into the shadow register.
REQ-008 Port blank, input, 1, level that forces all digits dark.
REQ-009 Port seg, output, 7 (bits 7:1), active-low segments: bit1 = a through bit7 = g.
REQ-010 Port dp_n, output, 1, active-low decimal point for the selected digit.
REQ-011 Port an, output, NUM_DIGITS, active-low digit select, at most one bit low.
REQ-012 Port frame_done, output, 1, one-cycle pulse when the display register reloads.

Function
REQ-013 Prescaler cnt (DIV_WIDTH bits) SHALL increment every clock and wrap to 0; tick SHALL be true when cnt is all ones.
REQ-014 Digit index idx SHALL advance on tick, 0 -> 1 -> ... -> NUM_DIGITS-1 -> 0, and SHALL hold otherwise.
REQ-015 On load, shadow SHALL capture {dp, value} on that clock edge; load held high SHALL re-capture every cycle.
REQ-016 On tick with idx = NUM_DIGITS-1 (frame wrap), disp SHALL take shadow as it stood before that edge, and frame_done SHALL be 1 in the following cycle only.
REQ-017 If load and the frame wrap coincide, the new value SHALL go to shadow only and SHALL reach disp at the next wrap.
REQ-018 Segment code per nibble SHALL be, as 7-bit g..a: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-019 seg, dp_n and an SHALL be registered, and the value in cycle n+1 SHALL reflect idx, disp and blank in cycle n (one-cycle latency).
REQ-020 For the selected digit, an[idx] SHALL be 0 and all other an bits 1; seg SHALL show the decoded nibble of digit idx; dp_n SHALL equal ~dp bit idx of disp.
REQ-021 While blank = 1, an, seg and dp_n SHALL be all ones; cnt, idx, shadow and disp SHALL keep operating.
REQ-022 A load between wraps SHALL never change the visible digits mid-frame.

Reset
REQ-023 With rst = 1 at an edge, cnt, idx, shadow, disp and frame_done SHALL clear to 0, and an, seg and dp_n SHALL go to all ones.
REQ-024 Reset SHALL take priority over load, tick and blank, including in the middle of a frame.
REQ-025 In the first cycle after reset release, outputs SHALL remain all ones; from the second cycle, digit 0 SHALL be selected and show "0" (seg = 1000000).

Configuration
REQ-026 Macro HEX_SCAN_LZB_EN SHALL enable leading-zero blanking.
REQ-027 With HEX_SCAN_LZB_EN defined, digit k > 0 SHALL be dark (its an bit 1, seg and dp_n all ones) when nibble k and all higher nibbles of disp are 0 and their dp bits are 0; digit 0 SHALL never be blanked.
REQ-028 Without HEX_SCAN_LZB_EN, all digits SHALL always display, and the leading-zero logic SHALL be absent.

Verification
REQ-029 NUM_DIGITS=4, DIV_WIDTH=2, reset released -> an steps 1110, 1101, 1011, 0111, 1110 every 4 clocks; frame_done pulses every 16 clocks.
REQ-030 load value=16'h12AF mid-frame -> no change until the next wrap; then digit 0 seg=0001110 (F), digit 1 seg=0001000 (A), digit 2 seg=0100100, digit 3 seg=1111001.
REQ-031 load coincident with the wrap tick, value=16'h0005 after 16'h12AF -> 12AF persists one more frame, then 0005 shows.
REQ-032 LZB_EN defined, disp=16'h0050, dp=0000 -> digits 2 and 3 dark, digit 1 shows 5, digit 0 shows 0; without the macro -> digits 3 and 2 show 0.
REQ-033 blank=1 for 10 cycles -> an=1111, seg=1111111, dp_n=1; idx continues and resumes at the correct digit when blank drops.
REQ-034 rst asserted mid-frame with idx=2 -> next cycle all outputs ones and idx=0; the display restarts from digit 0 showing 0.
